// File: rtl/sig_gen_pkg.sv
// Shared types for the signal-generator address path and its ROM/top-level wrappers.
package sig_gen_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        TRI     = 2'b01,
        ONESHOT = 2'b10,
        HOLD    = 2'b11
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/addr_step.sv
// Next-state function of the address generator: one step of FREE/TRI/ONESHOT/HOLD.
module addr_step
    import sig_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] incr_act,
    input  mode_t            mode,
    input  dir_t             dir,
    input  logic             busy,
    input  logic             start,
    output logic [WIDTH-1:0] count_next,
    output dir_t             dir_next,
    output logic             busy_next,
    output logic             wrap_next
);

    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    logic [WIDTH:0] sum_s;
    logic           incr_zero_s;

    // Per-mode step; dir and busy fall back to UP/0 outside their own mode so leaving it clears them.
    always_comb begin
        sum_s       = {1'b0, count} + {1'b0, incr_act};
        incr_zero_s = (incr_act == ZERO);
        count_next  = count;
        dir_next    = UP;
        busy_next   = 1'b0;
        wrap_next   = 1'b0;
        case (mode)
            FREE: begin
                if (!incr_zero_s) begin
                    count_next = sum_s[WIDTH-1:0];
                    wrap_next  = sum_s[WIDTH];
                end else begin
                    count_next = count;
                end
            end
            TRI: begin
                if (incr_zero_s) begin
                    dir_next = dir;
                end else if (dir == UP) begin
                    if (sum_s >= MAX_EXT) begin
                        count_next = MAX;
                        dir_next   = DOWN;
                    end else begin
                        count_next = sum_s[WIDTH-1:0];
                        dir_next   = UP;
                    end
                end else begin
                    if (count <= incr_act) begin
                        count_next = ZERO;
                        dir_next   = UP;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count - incr_act;
                        dir_next   = DOWN;
                    end
                end
            end
            ONESHOT: begin
                if (!busy) begin
                    if (start) begin
                        count_next = ZERO;
                        busy_next  = 1'b1;
                    end else begin
                        busy_next  = 1'b0;
                    end
                end else if (incr_zero_s) begin
                    busy_next = 1'b1;
                end else if (sum_s >= MAX_EXT) begin
                    count_next = MAX;
                    busy_next  = 1'b0;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = sum_s[WIDTH-1:0];
                    busy_next  = 1'b1;
                end
            end
            HOLD: begin
                count_next = count;
            end
            default: begin
                count_next = count;
            end
        endcase
    end

endmodule

// File: rtl/sig_addr_gen.sv
// Programmable ROM address generator: stepped channel A, phase-offset channel B and wrap pulse.
module sig_addr_gen
    import sig_gen_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] INCR_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] incr,
    input  logic [WIDTH-1:0] ofst,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_ofst,
    output logic             wrap,
    output logic             busy
);

    logic [WIDTH-1:0] count_r, count_ofst_r, incr_act_r;
    logic             wrap_r, busy_r;
    dir_t             dir_r;

    logic [WIDTH-1:0] step_count_s, count_d_s, incr_d_s;
    dir_t             step_dir_s, dir_d_s;
    logic             step_busy_s, step_wrap_s, busy_d_s, wrap_d_s;

    addr_step #(.WIDTH(WIDTH)) u_step (
        .count      (count_r),
        .incr_act   (incr_act_r),
        .mode       (mode_t'(mode)),
        .dir        (dir_r),
        .busy       (busy_r),
        .start      (start),
        .count_next (step_count_s),
        .dir_next   (step_dir_s),
        .busy_next  (step_busy_s),
        .wrap_next  (step_wrap_s)
    );

    // Enable gating; the increment shadow reloads while disabled or on a wrapping step.
    always_comb begin
        count_d_s = count_r;
        dir_d_s   = dir_r;
        busy_d_s  = busy_r;
        wrap_d_s  = 1'b0;
        incr_d_s  = incr_act_r;
        if (en) begin
            count_d_s = step_count_s;
            dir_d_s   = step_dir_s;
            busy_d_s  = step_busy_s;
            wrap_d_s  = step_wrap_s;
        end else begin
            wrap_d_s  = 1'b0;
        end
        if (!en || wrap_d_s) begin
            incr_d_s = incr;
        end else begin
            incr_d_s = incr_act_r;
        end
    end

    // State registers; active-low synchronous reset dominates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r      <= {WIDTH{1'b0}};
            count_ofst_r <= {WIDTH{1'b0}};
            wrap_r       <= 1'b0;
            busy_r       <= 1'b0;
            dir_r        <= UP;
            incr_act_r   <= INCR_RST;
        end else begin
            count_r      <= count_d_s;
            count_ofst_r <= count_d_s + ofst;
            wrap_r       <= wrap_d_s;
            busy_r       <= busy_d_s;
            dir_r        <= dir_d_s;
            incr_act_r   <= incr_d_s;
        end
    end

    assign count      = count_r;
    assign count_ofst = count_ofst_r;
    assign wrap       = wrap_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_sig_addr_gen.sv
// Directed bench for sig_addr_gen (WIDTH=8, INCR_RST=1) with hand-computed expectations.
module tb_sig_addr_gen;

    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [1:0] mode;
    logic [7:0] incr, ofst;
    logic [7:0] count, count_ofst;
    logic       wrap, busy;

    int n_tests = 0;
    int n_fail  = 0;

    sig_addr_gen #(.WIDTH(8), .INCR_RST(8'd1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .incr       (incr),
        .ofst       (ofst),
        .start      (start),
        .count      (count),
        .count_ofst (count_ofst),
        .wrap       (wrap),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One step, then check count / wrap / busy.
    task automatic stc(input string tag, input logic [7:0] c, input logic w, input logic b);
        step();
        chk({tag, ".count"}, count, c);
        chk({tag, ".wrap"},  wrap,  w);
        chk({tag, ".busy"},  busy,  b);
    endtask

    localparam logic [1:0] M_FREE = 2'b00, M_TRI = 2'b01, M_ONE = 2'b10, M_HOLD = 2'b11;

    logic [7:0] tri_seq [0:6] = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    logic       tri_wr  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; en = 1'b1; start = 1'b0; mode = M_FREE; incr = 8'd5; ofst = 8'd0;

        // reset state
        stc("rst", 8'd0, 1'b0, 1'b0);
        chk("rst.ofst", count_ofst, 8'd0);

        // FREE wrap with offset; en=0 first loads incr_act=64
        rst = 1'b1; en = 1'b0; incr = 8'd64; ofst = 8'd16;
        stc("load64", 8'd0, 1'b0, 1'b0);
        en = 1'b1;
        stc("free1", 8'd64, 1'b0, 1'b0);  chk("free1.ofst", count_ofst, 8'd80);
        stc("free2", 8'd128, 1'b0, 1'b0);
        stc("free3", 8'd192, 1'b0, 1'b0); chk("free3.ofst", count_ofst, 8'd208);
        stc("free4", 8'd0, 1'b1, 1'b0);   chk("free4.ofst", count_ofst, 8'd16);

        // shadowed increment: change takes effect after the next wrap
        stc("shd0", 8'd64, 1'b0, 1'b0);
        incr = 8'd1;
        stc("shd1", 8'd128, 1'b0, 1'b0);
        stc("shd2", 8'd192, 1'b0, 1'b0);
        stc("shd3", 8'd0, 1'b1, 1'b0);
        stc("shd4", 8'd1, 1'b0, 1'b0);
        stc("shd5", 8'd2, 1'b0, 1'b0);

        // en=0 freeze, HOLD freeze, resume
        en = 1'b0;
        for (int i = 0; i < 3; i++) stc("en0", 8'd2, 1'b0, 1'b0);
        en = 1'b1;
        stc("en1", 8'd3, 1'b0, 1'b0);
        ofst = 8'd10;
        mode = M_HOLD;
        stc("hold1", 8'd3, 1'b0, 1'b0);   chk("hold1.ofst", count_ofst, 8'd13);
        stc("hold2", 8'd3, 1'b0, 1'b0);
        mode = M_FREE;
        stc("resume", 8'd4, 1'b0, 1'b0);

        // TRI: reset, load incr=100, run the bounce
        rst = 1'b0; en = 1'b0; incr = 8'd100;
        stc("rst2", 8'd0, 1'b0, 1'b0);
        rst = 1'b1;
        stc("load100", 8'd0, 1'b0, 1'b0);
        en = 1'b1; mode = M_TRI;
        for (int i = 0; i < 7; i++) stc($sformatf("tri%0d", i), tri_seq[i], tri_wr[i], 1'b0);
        incr = 8'd0; en = 1'b0;
        stc("tri_load0", 8'd100, 1'b0, 1'b0);
        en = 1'b1;
        stc("tri_z1", 8'd100, 1'b0, 1'b0);
        stc("tri_z2", 8'd100, 1'b0, 1'b0);

        // ONESHOT sweep
        incr = 8'd100; en = 1'b0; mode = M_ONE;
        stc("one_load", 8'd100, 1'b0, 1'b0);
        en = 1'b1; start = 1'b1;
        stc("one_start", 8'd0, 1'b0, 1'b1);
        stc("one_busy_start", 8'd100, 1'b0, 1'b1);
        start = 1'b0;
        stc("one2", 8'd200, 1'b0, 1'b1);
        stc("one3", 8'd255, 1'b1, 1'b0);
        chk("one3.ofst", count_ofst, 8'd9);
        stc("one_hold", 8'd255, 1'b0, 1'b0);
        en = 1'b0; start = 1'b1;
        stc("one_en0_start", 8'd255, 1'b0, 1'b0);
        en = 1'b1;
        stc("one_restart", 8'd0, 1'b0, 1'b1);
        start = 1'b0;
        stc("one_r1", 8'd100, 1'b0, 1'b1);

        // reset mid-sweep aborts with no wrap
        rst = 1'b0;
        stc("rst_mid", 8'd0, 1'b0, 1'b0);
        chk("rst_mid.ofst", count_ofst, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
